// File: rtl/mossbauer_drive_gen.sv
// Mossbauer velocity-drive reference: symmetric triangular DAC code with valid/ready handoff.
// Optional endpoint dwell is built in when the DRIVE_DWELL_EN macro is defined.
module mossbauer_drive_gen #(
  parameter int unsigned DW          = 8,
  parameter int unsigned VMIN        = 0,
  parameter int unsigned VMAX        = 255,
  parameter int unsigned STEP_DIV    = 1000,
  parameter int unsigned DWELL_TICKS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          dac_ready,
  output logic [DW-1:0] dac_code,
  output logic          dac_valid,
  output logic          dir,
  output logic [DW:0]   chan_idx,
  output logic          sweep_sync,
  output logic          stall_err
);

  localparam int unsigned   CW         = DW + 1;
  localparam int unsigned   PW         = $clog2(STEP_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);
  localparam logic [DW-1:0] CODE_MIN   = DW'(VMIN);
  localparam logic [DW-1:0] CODE_MIN1  = DW'(VMIN + 1);
  localparam logic [DW-1:0] CODE_MAX   = DW'(VMAX);
  localparam bit            DEGEN      = (VMAX == VMIN + 1);

  typedef enum logic [2:0] {
    IDLE, PARK, RAMP_UP, RAMP_DOWN, DWELL_TOP, DWELL_BOT
  } state_t;

`ifdef DRIVE_DWELL_EN
  localparam bit             HAS_DWELL  = (DWELL_TICKS > 0);
  localparam int unsigned    DCW        = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL_TICKS - 1);
  localparam state_t         BOT_ST     = HAS_DWELL ? DWELL_BOT : RAMP_UP;
  localparam state_t         TOP_ST     = HAS_DWELL ? DWELL_TOP : RAMP_UP;
  logic [DCW-1:0] dwell_cnt;
`else
  localparam state_t BOT_ST = RAMP_UP;
  localparam state_t TOP_ST = RAMP_UP;
`endif

  // Reject parameter sets the code/channel arithmetic cannot represent.
  if (VMIN >= VMAX || (VMAX >> DW) != 0 || STEP_DIV < 2 || DWELL_TICKS > 65535) begin : g_bad_params
    $error("mossbauer_drive_gen: invalid parameter set");
  end

  state_t        state;
  logic [PW-1:0] presc;
  logic          run;
  logic          tick;
  logic          accept;
  logic          can_step;

  assign run      = (state != IDLE) && (state != PARK);
  assign tick     = run && (presc == PRESC_LAST);
  assign accept   = dac_valid && dac_ready;
  assign can_step = !dac_valid || dac_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      presc      <= '0;
      dac_code   <= CODE_MIN;
      dac_valid  <= 1'b0;
      dir        <= 1'b0;
      chan_idx   <= '0;
      sweep_sync <= 1'b0;
      stall_err  <= 1'b0;
`ifdef DRIVE_DWELL_EN
      dwell_cnt  <= '0;
`endif
    end else begin
      sweep_sync <= 1'b0;
      if (accept) dac_valid <= 1'b0;
      if (run) presc <= tick ? '0 : presc + PW'(1);

      if (run && !en) begin
        // Park the transducer at VMIN and wait for the DAC to take it.
        state     <= PARK;
        presc     <= '0;
        dac_code  <= CODE_MIN;
        dac_valid <= 1'b1;
`ifdef DRIVE_DWELL_EN
        dwell_cnt <= '0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (en) begin
              state      <= BOT_ST;
              dac_code   <= CODE_MIN;
              chan_idx   <= '0;
              dir        <= 1'b1;
              dac_valid  <= 1'b1;
              sweep_sync <= 1'b1;
              stall_err  <= 1'b0;
            end
          end
          PARK: begin
            if (accept) begin
              state    <= IDLE;
              dir      <= 1'b0;
              chan_idx <= '0;
            end
          end
          RAMP_UP: begin
            if (tick) begin
              if (!can_step) begin
                stall_err <= 1'b1;
              end else if (dac_code == CODE_MAX) begin
                if (DEGEN) begin
                  state      <= BOT_ST;
                  dac_code   <= CODE_MIN;
                  chan_idx   <= '0;
                  dir        <= 1'b1;
                  dac_valid  <= 1'b1;
                  sweep_sync <= 1'b1;
                end else begin
                  state     <= RAMP_DOWN;
                  dac_code  <= dac_code - DW'(1);
                  chan_idx  <= chan_idx + CW'(1);
                  dir       <= 1'b0;
                  dac_valid <= 1'b1;
                end
              end else begin
                dac_code  <= dac_code + DW'(1);
                chan_idx  <= chan_idx + CW'(1);
                dac_valid <= 1'b1;
                if (dac_code + DW'(1) == CODE_MAX) state <= TOP_ST;
              end
            end
          end
          RAMP_DOWN: begin
            if (tick) begin
              if (!can_step) begin
                stall_err <= 1'b1;
              end else if (dac_code == CODE_MIN1) begin
                state      <= BOT_ST;
                dac_code   <= CODE_MIN;
                chan_idx   <= '0;
                dir        <= 1'b1;
                dac_valid  <= 1'b1;
                sweep_sync <= 1'b1;
              end else begin
                dac_code  <= dac_code - DW'(1);
                chan_idx  <= chan_idx + CW'(1);
                dac_valid <= 1'b1;
              end
            end
          end
`ifdef DRIVE_DWELL_EN
          // Endpoint hold: no new transfers, so DAC backpressure cannot stall it.
          DWELL_TOP, DWELL_BOT: begin
            if (tick) begin
              if (dwell_cnt == DWELL_LAST) begin
                state     <= RAMP_UP;
                dwell_cnt <= '0;
              end else begin
                dwell_cnt <= dwell_cnt + DCW'(1);
              end
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mossbauer_drive_gen.sv
// Self-checking bench for mossbauer_drive_gen against a sweep-table reference model.
// Honours DRIVE_DWELL_EN when the design is built with endpoint dwell.
module tb_mossbauer_drive_gen;

  localparam int unsigned DW          = 8;
  localparam int unsigned VMIN        = 0;
  localparam int unsigned VMAX        = 4;
  localparam int unsigned STEP_DIV    = 3;
  localparam int unsigned DWELL_TICKS = 2;
`ifdef DRIVE_DWELL_EN
  localparam int unsigned D = DWELL_TICKS;
`else
  localparam int unsigned D = 0;
`endif
  localparam int unsigned N      = VMAX - VMIN;
  localparam int unsigned P      = 2 * N + 2 * D;
  localparam int unsigned PERIOD = P * STEP_DIV;
  localparam int unsigned VW     = 2 * DW + 5;
  localparam logic [VW-1:0] RESET_VEC = {DW'(VMIN), 1'b0, 1'b0, (DW + 1)'(0), 1'b0, 1'b0};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          dac_ready = 1'b0;
  logic [DW-1:0] dac_code;
  logic          dac_valid;
  logic          dir;
  logic [DW:0]   chan_idx;
  logic          sweep_sync;
  logic          stall_err;

  mossbauer_drive_gen #(
    .DW(DW), .VMIN(VMIN), .VMAX(VMAX), .STEP_DIV(STEP_DIV), .DWELL_TICKS(DWELL_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dac_ready(dac_ready),
    .dac_code(dac_code), .dac_valid(dac_valid), .dir(dir), .chan_idx(chan_idx),
    .sweep_sync(sweep_sync), .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  wire [VW-1:0] act = {dac_code, dac_valid, dir, chan_idx, sweep_sync, stall_err};

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // One full sweep as a table of tick slots; xfer=0 marks an endpoint hold slot.
  int seq_code[P];
  int seq_chan[P];
  bit seq_dir[P];
  bit seq_xfer[P];

  // Model: mode 0=idle, 1=running, 2=parking.
  int m_mode = 0, m_pos = 0, m_phase = 0, m_code = VMIN, m_chan = 0;
  bit m_valid = 0, m_dir = 0, m_sync = 0, m_stall = 0;
  logic [VW-1:0] expv = RESET_VEC;

  function automatic void build_table();
    int k = 0;
    for (int c = VMIN; c <= int'(VMAX); c++) begin
      seq_code[k] = c; seq_chan[k] = c - VMIN; seq_dir[k] = 1'b1; seq_xfer[k] = 1'b1; k++;
      if (c == VMIN || c == VMAX)
        for (int h = 0; h < int'(D); h++) begin
          seq_code[k] = c; seq_chan[k] = c - VMIN; seq_dir[k] = 1'b1; seq_xfer[k] = 1'b0; k++;
        end
    end
    for (int c = VMAX - 1; c > int'(VMIN); c--) begin
      seq_code[k] = c; seq_chan[k] = 2 * N - (c - VMIN); seq_dir[k] = 1'b0; seq_xfer[k] = 1'b1; k++;
    end
  endfunction

  function automatic void load_slot(int k);
    m_pos = k; m_code = seq_code[k]; m_chan = seq_chan[k]; m_dir = seq_dir[k];
    m_valid = 1'b1; m_sync = (k == 0);
  endfunction

  function automatic void model_update();
    bit acc;
    int np;
    if (!rst_n) begin
      m_mode = 0; m_pos = 0; m_phase = 0; m_code = VMIN; m_chan = 0;
      m_valid = 0; m_dir = 0; m_sync = 0; m_stall = 0;
    end else begin
      acc = m_valid && dac_ready;
      m_sync = 1'b0;
      if (acc) m_valid = 1'b0;
      case (m_mode)
        0: if (en) begin m_mode = 1; m_phase = 0; m_stall = 1'b0; load_slot(0); end
        1: begin
          if (!en) begin
            m_mode = 2; m_code = VMIN; m_valid = 1'b1; m_phase = 0;
          end else if (m_phase == int'(STEP_DIV) - 1) begin
            m_phase = 0;
            np = (m_pos + 1) % P;
            if (!seq_xfer[np]) m_pos = np;
            else if (m_valid && !dac_ready) m_stall = 1'b1;
            else load_slot(np);
          end else begin
            m_phase++;
          end
        end
        default: if (acc) begin m_mode = 0; m_dir = 1'b0; m_chan = 0; end
      endcase
    end
    expv = {DW'(m_code), m_valid, m_dir, (DW + 1)'(m_chan), m_sync, m_stall};
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; dac_ready = 1'b0;
    step(); step();
    checks++;
    if (act !== RESET_VEC) begin
      errors++; $display("FAIL reset_values cyc=%0d act=%h exp=%h", cyc, act, RESET_VEC);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (act !== expv) begin errors++; $display("FAIL idle_hold cyc=%0d act=%h exp=%h", cyc, act, expv); end
    end
  endtask

  task automatic test_basic_sweep();
    int last_sync = -1;
    int max_chan = 0;
    en = 1'b1; dac_ready = 1'b1;
    for (int i = 0; i < int'(2 * PERIOD + 4); i++) begin
      step();
      checks++;
      if (act !== expv) begin errors++; $display("FAIL basic_sweep cyc=%0d act=%h exp=%h", cyc, act, expv); end
      if (int'(chan_idx) > max_chan) max_chan = int'(chan_idx);
      if (sweep_sync) begin
        if (last_sync >= 0) begin
          checks++;
          if (cyc - last_sync != int'(PERIOD)) begin
            errors++; $display("FAIL sync_period got=%0d want=%0d", cyc - last_sync, PERIOD);
          end
        end
        last_sync = cyc;
      end
    end
    checks++;
    if (max_chan != int'(2 * N - 1)) begin
      errors++; $display("FAIL chan_span got=%0d want=%0d", max_chan, 2 * N - 1);
    end
  endtask

  task automatic test_backpressure();
    bit found = 0;
    dac_ready = 1'b1;
    for (int i = 0; i < int'(2 * PERIOD) && !found; i++) begin
      step();
      checks++;
      if (act !== expv) begin errors++; $display("FAIL bp_wait cyc=%0d act=%h exp=%h", cyc, act, expv); end
      found = (dac_code == DW'(2)) && dac_valid && dir;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL bp_reach_code2 got=%0d want=2", dac_code); end
    dac_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (act !== expv) begin errors++; $display("FAIL bp_stall cyc=%0d act=%h exp=%h", cyc, act, expv); end
    end
    checks++;
    if (dac_code !== DW'(2) || dac_valid !== 1'b1 || stall_err !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold got code=%0d valid=%b stall=%b want code=2 valid=1 stall=1",
               dac_code, dac_valid, stall_err);
    end
    dac_ready = 1'b1;
    found = 0;
    for (int i = 0; i < int'(3 * STEP_DIV + 2) && !found; i++) begin
      step();
      checks++;
      if (act !== expv) begin errors++; $display("FAIL bp_resume cyc=%0d act=%h exp=%h", cyc, act, expv); end
      found = (dac_code == DW'(3));
    end
    checks++;
    if (!found || stall_err !== 1'b1) begin
      errors++; $display("FAIL bp_resume_code3 got code=%0d stall=%b want code=3 stall=1", dac_code, stall_err);
    end
  endtask

  task automatic test_park();
    bit found = 0;
    en = 1'b1; dac_ready = 1'b1;
    for (int i = 0; i < int'(2 * PERIOD) && !found; i++) begin
      step();
      checks++;
      if (act !== expv) begin errors++; $display("FAIL park_wait cyc=%0d act=%h exp=%h", cyc, act, expv); end
      found = (dac_code == DW'(3)) && !dir;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL park_reach_down3 got code=%0d dir=%b want 3/0", dac_code, dir); end
    en = 1'b0; dac_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (act !== expv) begin errors++; $display("FAIL park_hold cyc=%0d act=%h exp=%h", cyc, act, expv); end
    end
    checks++;
    if (dac_code !== DW'(VMIN) || dac_valid !== 1'b1) begin
      errors++; $display("FAIL park_code got code=%0d valid=%b want %0d/1", dac_code, dac_valid, VMIN);
    end
    dac_ready = 1'b1;
    step();
    checks++;
    if (dac_valid !== 1'b0 || dir !== 1'b0 || chan_idx !== '0 || dac_code !== DW'(VMIN)) begin
      errors++;
      $display("FAIL park_to_idle got valid=%b dir=%b chan=%0d code=%0d want 0/0/0/%0d",
               dac_valid, dir, chan_idx, dac_code, VMIN);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (act !== expv) begin errors++; $display("FAIL park_idle cyc=%0d act=%h exp=%h", cyc, act, expv); end
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    en = 1'b1; dac_ready = 1'b1;
    for (int i = 0; i < int'(2 * PERIOD) && !found; i++) begin
      step();
      checks++;
      if (act !== expv) begin errors++; $display("FAIL rst_wait cyc=%0d act=%h exp=%h", cyc, act, expv); end
      found = (dac_code == DW'(4));
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rst_reach_code4 got=%0d want=4", dac_code); end
    rst_n = 1'b0;
    step();
    checks++;
    if (act !== RESET_VEC) begin errors++; $display("FAIL rst_mid cyc=%0d act=%h exp=%h", cyc, act, RESET_VEC); end
    rst_n = 1'b1;
    step();
    checks++;
    if (sweep_sync !== 1'b1 || dac_code !== DW'(VMIN) || dac_valid !== 1'b1 || stall_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_restart got sync=%b code=%0d valid=%b stall=%b want 1/%0d/1/0",
               sweep_sync, dac_code, dac_valid, stall_err, VMIN);
    end
    for (int i = 0; i < int'(PERIOD); i++) begin
      step();
      checks++;
      if (act !== expv) begin errors++; $display("FAIL rst_after cyc=%0d act=%h exp=%h", cyc, act, expv); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) en = !en;
      dac_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 499) != 0);
      step();
      checks++;
      if (act !== expv) begin errors++; $display("FAIL random cyc=%0d act=%h exp=%h", cyc, act, expv); end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    build_table();
    test_reset();
    test_basic_sweep();
    test_backpressure();
    test_park();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d limit=50000", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mossbauer_drive_gen.md
# mossbauer_drive_gen

Velocity-drive reference generator for the Mössbauer spectrometer. Produces the symmetric triangular velocity code (the RF1 drive waveform) that the transducer DAC plays out and that the coincidence gate thresholds against, plus a direction flag, a per-step channel index and a sweep-start sync for the spectrum accumulator. Updates reach the DAC through a valid/ready handshake, so a slow DAC interface stretches the sweep instead of corrupting it.

## Interface
- DW, 8: DAC code width.
- VMIN, 0: lowest code of the sweep.
- VMAX, 255: highest code of the sweep; VMIN < VMAX <= 2^DW-1.
- STEP_DIV, 1000: clk cycles per velocity step; >= 2.
- DWELL_TICKS, 4: extra step ticks held at each endpoint; used only with DRIVE_DWELL_EN.
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  run request; level-sensitive.
- dac_ready  in  1  DAC interface accepts dac_code this cycle.
- dac_code  out  DW  current velocity code.
- dac_valid  out  1  dac_code holds a new, not-yet-accepted value.
- dir  out  1  1 = ramp up (positive velocity slope), 0 = ramp down.
- chan_idx  out  DW+1  spectrum channel, 0 .. 2*(VMAX-VMIN)-1.
- sweep_sync  out  1  one-cycle pulse at each sweep start (code = VMIN, chan_idx = 0).
- stall_err  out  1  sticky: a step tick was dropped because of DAC backpressure.

## Operation
- States: IDLE, PARK, RAMP_UP, RAMP_DOWN; plus DWELL_TOP and DWELL_BOT with DRIVE_DWELL_EN.
- Prescaler counts 0..STEP_DIV-1 while in a ramp or dwell state and emits a one-cycle tick on its terminal count. It is held at 0 in IDLE/PARK.
- Transfer rule: a new code loads dac_code and sets dac_valid. dac_valid clears on the cycle where dac_valid && dac_ready.
- On a tick while dac_valid && !dac_ready: the tick is dropped, code and state are unchanged, and stall_err is set.
- IDLE, when en=1: enter RAMP_UP with code=VMIN, chan_idx=0, dir=1, dac_valid=1 and a sweep_sync pulse.
- RAMP_UP, on tick: code+1, chan_idx+1. When the code is VMAX, the tick instead enters RAMP_DOWN with code VMAX-1 and dir=0.
- RAMP_DOWN, on tick: code-1, chan_idx+1. When the code is VMIN+1, the tick instead enters RAMP_UP with code=VMIN, chan_idx=0, dir=1 and a sweep_sync pulse.
- Resulting period: 2*(VMAX-VMIN) steps with the sequence VMIN..VMAX, VMAX-1..VMIN+1. Degenerate case VMAX=VMIN+1 gives VMIN, VMAX, VMIN, ...
- chan_idx arithmetic is unsigned DW+1 bits and never exceeds 2*(VMAX-VMIN)-1.
- en=0 in any run state: go to PARK, load code=VMIN, set dac_valid=1, and hold until accepted. Then go to IDLE; dir, chan_idx and the prescaler go to 0.
- en=1 during PARK: finish PARK first, then start from IDLE.
- stall_err clears only on reset or on the IDLE→RAMP_UP start.

## Timing
- Reset values: dac_code=VMIN, dac_valid=0, dir=0, chan_idx=0, sweep_sync=0, stall_err=0, state IDLE, prescaler 0.
- Reset mid-sweep takes effect on the next posedge, with no PARK transfer.
- en sampled high in IDLE at edge N: dac_valid, sweep_sync and code VMIN all appear after edge N.
- Step latency: outputs update on the edge after the tick. With continuous ready, consecutive codes are exactly STEP_DIV cycles apart.
- sweep_sync is exactly one cycle wide and coincides with the first cycle of the dac_valid that carries VMIN.
- A tick and acceptance in the same cycle count as accepted: the step proceeds, no stall.
- All outputs are registered.

## Configuration
- DRIVE_DWELL_EN defined: reaching VMAX in RAMP_UP enters DWELL_TOP, and entering VMIN (after the sync) enters DWELL_BOT.
  - Each dwell state holds the code for DWELL_TICKS ticks, with no dac_valid and chan_idx frozen, then resumes the ramp.
  - The period becomes 2*(VMAX-VMIN)+2*DWELL_TICKS ticks, and the channel count is unchanged.
- DRIVE_DWELL_EN undefined: no dwell states and DWELL_TICKS is ignored.

## Test plan
- Basic sweep: VMIN=0, VMAX=4, STEP_DIV=3, dac_ready=1, en=1. Codes follow 0,1,2,3,4,3,2,1,0,... at a 3-cycle spacing; dir=1 for codes 0..4 on the up ramp; chan_idx 0..7; sweep_sync at each code-0 entry (every 24 cycles).
- Backpressure: same setup with dac_ready=0 for 10 cycles at code 2. dac_code holds 2, dac_valid stays 1, stall_err=1 and stays set; the sweep resumes at 3 after acceptance.
- Stop and park: en drops at code 3 on the down ramp, with ready=0 for 5 cycles. dac_code=0 and dac_valid=1 are held until ready; then IDLE with dir=0 and chan_idx=0.
- Reset mid-ramp: rst_n low for 1 cycle at code 4. All outputs take reset values on the next edge, with no dac_valid; re-enabling starts at 0 with sweep_sync.
- Dwell build: DRIVE_DWELL_EN, DWELL_TICKS=2, VMIN=0, VMAX=4, STEP_DIV=3. Code 4 holds for 9 cycles and code 0 for 9 cycles; the period is 36 cycles; chan_idx still spans 0..7.
